gshare_index: RTL and testbench
===============================

// Module: gshare_index
// PURPOSE
//  Global-history index generator feeding the pattern history table in FETCH.
//  Holds a speculative global history (shifted by PHT predictions at lookup)
//  and a committed history (shifted by resolved outcomes from DECODE).
//  Produces index = PC bits XOR history. Restores speculative history on a mispredict.
//  Keeps an in-flight FIFO of predictions so each resolved outcome is checked
//  against its own prediction.
// PARAMETERS
//  IWIDTH  6  PHT index width; must match the PHT IWIDTH
//  HWIDTH  4  global history length; must be >=2
//  PC_LSB  2  lowest PC bit used in the index
//  DEPTH   4  in-flight prediction FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high reset
//  en          in   1       stall gate; when 0, no state changes
//  do_lookup   in   1       instruction in FETCH is a branch
//  pc          in   32      FETCH PC
//  pred        in   1       PHT prediction for the current lookup
//  do_update   in   1       instruction in DECODE is a branch
//  last_taken  in   1       resolved outcome of that branch
//  index       out  IWIDTH  PHT index (combinational)
//  spec_hist   out  HWIDTH  speculative history register
//  mispredict  out  1       registered 1-cycle pulse: resolved outcome != FIFO head
//  full        out  1       FIFO count == DEPTH
//  empty       out  1       FIFO count == 0
//  overflow    out  1       sticky: lookup attempted while full
// BEHAVIOUR
//  - Reset (clk edge with reset=1): spec_hist=0, commit_hist=0, count=0, rd/wr ptr=0,
//    mispredict=0, overflow=0. Reset has priority over en. It aborts any in-flight state.
//  - index = pc[PC_LSB+:IWIDTH] ^ H. Without GSHARE_FOLD_EN, H = spec_hist zero-extended
//    to IWIDTH (HWIDTH<=IWIDTH required). index is combinational in the same cycle: zero latency.
//  - Lookup (en & do_lookup & !full): push pred, and spec_hist <= {spec_hist[HWIDTH-2:0],pred}.
//  - Lookup while full: push is dropped, spec_hist is unchanged, and overflow <= 1 (sticky until reset).
//  - Update (en & do_update): commit_hist <= {commit_hist[HWIDTH-2:0],last_taken}.
//     * FIFO non-empty: pop head. If head != last_taken, the following apply at that edge:
//       - mispredict <= 1.
//       - spec_hist <= {commit_hist[HWIDTH-2:0],last_taken}.
//       - FIFO is flushed: count=0, rd_ptr=wr_ptr.
//     * FIFO empty: no compare and mispredict <= 0. spec_hist <= new commit value (resync).
//  - Lookup and update in the same cycle:
//     * No mispredict: pop and push both happen, and count is unchanged.
//       - full stays full. The pop frees a slot, so the push is accepted and no overflow is set.
//       - spec_hist shifts by pred only; commit_hist shifts independently.
//     * Mispredict: recovery wins. The lookup push and its spec shift are discarded,
//       because that instruction is on the wrong path.
//  - mispredict is 0 in every cycle that does not follow a mispredicting update.
//    With en=0, mispredict <= 0 and all other state holds.
//  - Pointers wrap modulo DEPTH; count has width $clog2(DEPTH)+1.
// CONFIGURATION
//  GSHARE_FOLD_EN defined:
//   - HWIDTH may exceed IWIDTH.
//   - H = XOR of the ceil(HWIDTH/IWIDTH) IWIDTH-bit slices of spec_hist.
//   - The top slice is zero-padded.
//  GSHARE_FOLD_EN undefined:
//   - HWIDTH>IWIDTH is an elaboration error ($error).
//   - H = zero-extended spec_hist.
// TESTING  (IWIDTH=6, HWIDTH=4, PC_LSB=2, DEPTH=4)
//  1. Reset, then pc=0x000000F4 -> index=0x3D, spec_hist=0, empty=1, mispredict=0.
//  2. Three lookups with pred=1, then pc=0 ->
//     - spec_hist=4'b0111, index=6'h07, count=3.
//  3. Continue from 2: three updates with last_taken=1 ->
//     - mispredict stays 0, empty=1, commit_hist=4'b0111.
//  4. From reset: two lookups with pred=1, then an update with last_taken=0 ->
//     - next cycle: mispredict=1 for one cycle, spec_hist=4'b0000, empty=1.
//  5. From reset: four lookups, no update -> full=1.
//     - A 5th lookup -> overflow=1, spec_hist unchanged at 4'b1111 (pred=1).
//  6. With one entry holding pred=1, lookup (pred=1) and update (last_taken=0) in the same cycle ->
//     - mispredict=1, spec_hist=4'b0000, empty=1; the push is discarded.

Source files
------------

// File: rtl/gshare_index.sv
// gshare_index -- global-history index generator for the FETCH-stage PHT.
//
// Keeps two history registers:
//   spec_hist   : speculative history, shifted by the PHT prediction at lookup
//   commit_hist : committed history, shifted by resolved outcomes from DECODE
// The PHT index is pc[PC_LSB +: IWIDTH] ^ H, and it is produced combinationally.
// An in-flight FIFO records each prediction, so every resolved outcome is
// compared with its own prediction. When they differ, the module raises
// mispredict, flushes the FIFO and rebuilds spec_hist from the committed history.
//
// Optional build macro:
//   GSHARE_FOLD_EN : when defined, H is the XOR of the IWIDTH-bit slices of
//                    spec_hist (the top slice is zero-padded), and HWIDTH may
//                    exceed IWIDTH. When undefined, H is spec_hist zero-extended
//                    to IWIDTH, and HWIDTH > IWIDTH is an elaboration error.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset (reset beats en)
//   en              stall gate; when low, state holds and mispredict drops
//   do_lookup, pc, pred        FETCH-side branch lookup and PHT prediction
//   do_update, last_taken      DECODE-side resolved branch outcome
//   index           PHT index (combinational)
//   spec_hist       speculative history register
//   mispredict      registered 1-cycle pulse after a mispredicting update
//   full, empty     FIFO status
//   overflow        sticky: a lookup was dropped because the FIFO was full
module gshare_index #(
  parameter int IWIDTH = 6,
  parameter int HWIDTH = 4,
  parameter int PC_LSB = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              do_lookup,
  input  logic [31:0]       pc,
  input  logic              pred,
  input  logic              do_update,
  input  logic              last_taken,
  output logic [IWIDTH-1:0] index,
  output logic [HWIDTH-1:0] spec_hist,
  output logic              mispredict,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (HWIDTH < 2) begin : g_hw_min_err
    $error("gshare_index: HWIDTH must be >= 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_err
    $error("gshare_index: DEPTH must be a power of 2 and >= 2");
  end

  logic [HWIDTH-1:0] commit_hist;
  logic [DEPTH-1:0]  fifo;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  // Only a window of the PC feeds the index. The MSB of commit_hist shifts
  // out and is never read.
  logic [31:0] unused_pc;
  logic        unused_commit_msb;
  assign unused_pc         = pc;
  assign unused_commit_msb = commit_hist[HWIDTH-1];

  // ---------------- history hash ----------------
  logic [IWIDTH-1:0] h;
`ifdef GSHARE_FOLD_EN
  localparam int NS = (HWIDTH + IWIDTH - 1) / IWIDTH;
  logic [NS*IWIDTH-1:0] hpad;
  always_comb begin
    hpad = '0;
    hpad[HWIDTH-1:0] = spec_hist;
    h = '0;
    for (int s = 0; s < NS; s++) h = h ^ hpad[s*IWIDTH +: IWIDTH];
  end
`else
  if (HWIDTH > IWIDTH) begin : g_hw_err
    $error("gshare_index: HWIDTH > IWIDTH requires GSHARE_FOLD_EN");
    assign h = '0;
  end else begin : g_zext
    assign h = IWIDTH'(spec_hist);
  end
`endif

  assign index = pc[PC_LSB +: IWIDTH] ^ h;

  // ---------------- control ----------------
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  logic              lk, upd, pop, miss, push, ovf_set;
  logic [HWIDTH-1:0] new_commit, base_hist;

  always_comb begin
    lk         = en & do_lookup;
    upd        = en & do_update;
    new_commit = {commit_hist[HWIDTH-2:0], last_taken};
    pop        = upd & ~empty;
    miss       = pop & (fifo[rd_ptr] != last_taken);
    // A pop in the same cycle frees a slot for the push. On a mispredict the
    // lookup is on the wrong path, so its push is discarded.
    push       = lk & (~full | pop) & ~miss;
    ovf_set    = lk & full & ~pop;
    // An update on an empty FIFO resyncs spec_hist to the committed history.
    // A lookup in that same cycle is younger, so it shifts on top of the resync.
    base_hist  = (upd & empty) ? new_commit : spec_hist;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spec_hist   <= '0;
      commit_hist <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      mispredict  <= 1'b0;
      overflow    <= 1'b0;
      fifo        <= '0;
    end else begin
      mispredict <= miss;
      if (ovf_set) overflow <= 1'b1;
      if (upd) commit_hist <= new_commit;

      if (miss) begin
        spec_hist <= new_commit;
        count     <= '0;
        rd_ptr    <= wr_ptr;
      end else begin
        spec_hist <= push ? {base_hist[HWIDTH-2:0], pred} : base_hist;
        if (push) begin
          fifo[wr_ptr] <= pred;
          wr_ptr       <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_gshare_index.sv
module tb_gshare_index;
  logic        clk = 1'b0;
  logic        reset, en, do_lookup, pred, do_update, last_taken;
  logic [31:0] pc;
  logic [5:0]  index;
  logic [3:0]  spec_hist;
  logic        mispredict, full, empty, overflow;

  gshare_index #(.IWIDTH(6), .HWIDTH(4), .PC_LSB(2), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .do_lookup(do_lookup), .pc(pc),
    .pred(pred), .do_update(do_update), .last_taken(last_taken),
    .index(index), .spec_hist(spec_hist), .mispredict(mispredict),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Signal selectors used by the scoreboard entries.
  localparam int S_INDEX = 0, S_SPEC = 1, S_EMPTY = 2, S_MISP = 3,
                 S_FULL = 4, S_OVF = 5, S_COUNT = 6, S_COMMIT = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int total = 0, passed = 0;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      S_INDEX:  return 32'(index);
      S_SPEC:   return 32'(spec_hist);
      S_EMPTY:  return 32'(empty);
      S_MISP:   return 32'(mispredict);
      S_FULL:   return 32'(full);
      S_OVF:    return 32'(overflow);
      S_COUNT:  return 32'(dut.count);
      S_COMMIT: return 32'(dut.commit_hist);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(string name, int sel, logic [31:0] e);
    exp_t x;
    x.name = name; x.sel = sel; x.exp = e;
    q.push_back(x);
  endtask

  // Monitor: drains the expectations queued for this cycle, on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t x;
      logic [31:0] a;
      x = q.pop_front();
      a = actual(x.sel);
      total++;
      if (a === x.exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", x.name, a, x.exp);
    end
  end

  task automatic idle_inputs();
    do_lookup = 0; pred = 0; do_update = 0; last_taken = 0;
  endtask

  task automatic step(input logic lk, input logic p, input logic up, input logic lt);
    do_lookup = lk; pred = p; do_update = up; last_taken = lt;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs(); en = 1; reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    pc = 32'h0; en = 1; reset = 1; idle_inputs();

    // 1: reset state and zero-latency index
    do_reset();
    pc = 32'h0000_00F4;
    expect_val("rst_index", S_INDEX, 32'h3D);
    expect_val("rst_spec", S_SPEC, 32'h0);
    expect_val("rst_empty", S_EMPTY, 32'h1);
    expect_val("rst_misp", S_MISP, 32'h0);
    expect_val("rst_ovf", S_OVF, 32'h0);
    expect_val("rst_full", S_FULL, 32'h0);
    @(negedge clk);

    // 2: three taken lookups
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    pc = 32'h0;
    expect_val("lk3_spec", S_SPEC, 32'h7);
    expect_val("lk3_index", S_INDEX, 32'h07);
    expect_val("lk3_count", S_COUNT, 32'd3);
    @(negedge clk);

    // 3: three correct taken updates
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1);
      expect_val($sformatf("upd%0d_misp", i), S_MISP, 32'h0);
      @(negedge clk);
    end
    expect_val("upd3_empty", S_EMPTY, 32'h1);
    expect_val("upd3_commit", S_COMMIT, 32'h7);
    expect_val("upd3_spec", S_SPEC, 32'h7);
    @(negedge clk);

    // 4: mispredict recovery
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 1, 0);
    expect_val("mp_misp", S_MISP, 32'h1);
    expect_val("mp_spec", S_SPEC, 32'h0);
    expect_val("mp_empty", S_EMPTY, 32'h1);
    @(negedge clk);
    step(0, 0, 0, 0);
    expect_val("mp_pulse_end", S_MISP, 32'h0);
    @(negedge clk);

    // 5: fill the FIFO, then overflow
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    expect_val("fill_full", S_FULL, 32'h1);
    expect_val("fill_spec", S_SPEC, 32'hF);
    expect_val("fill_ovf", S_OVF, 32'h0);
    @(negedge clk);
    step(1, 0, 0, 0);
    expect_val("ovf_set", S_OVF, 32'h1);
    expect_val("ovf_spec", S_SPEC, 32'hF);
    expect_val("ovf_count", S_COUNT, 32'd4);
    @(negedge clk);
    step(0, 0, 0, 0);
    expect_val("ovf_sticky", S_OVF, 32'h1);
    @(negedge clk);

    // 6: same-cycle lookup and mispredicting update; the push is discarded
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    expect_val("sc_misp", S_MISP, 32'h1);
    expect_val("sc_spec", S_SPEC, 32'h0);
    expect_val("sc_empty", S_EMPTY, 32'h1);
    expect_val("sc_count", S_COUNT, 32'd0);
    @(negedge clk);

    // 7: same-cycle lookup and correct update; count holds, spec shifts by pred
    do_reset();
    step(1, 1, 0, 0);
    step(1, 0, 1, 1);
    expect_val("sc2_count", S_COUNT, 32'd1);
    expect_val("sc2_spec", S_SPEC, 32'h2);
    expect_val("sc2_commit", S_COMMIT, 32'h1);
    expect_val("sc2_misp", S_MISP, 32'h0);
    @(negedge clk);

    // 8: en=0 stalls all state
    do_reset();
    en = 0;
    step(1, 1, 1, 1);
    en = 1;
    expect_val("stall_spec", S_SPEC, 32'h0);
    expect_val("stall_empty", S_EMPTY, 32'h1);
    expect_val("stall_commit", S_COMMIT, 32'h0);
    @(negedge clk);

    // The monitor drains the queue on every falling edge, so it must be empty now.
    @(negedge clk); #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
